// File: rtl/req_rr_encoder16.sv
// Sticky request capture with round-robin selection of one pending line per transfer,
// presented one-hot and binary on a valid/ready output register.
module req_rr_encoder16 #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] y,
  output logic [N-1:0] onehot,
  output logic [N-1:0] pending,
  output logic         busy
);

  logic [N-1:0] r_pending;
  logic         r_valid;
  logic [W-1:0] r_y;
  logic [N-1:0] r_onehot;
  logic [W-1:0] r_ptr;

  logic [W-1:0] w_sel;
  logic         w_any;
  logic         w_load;
  logic         w_take;
  logic [N-1:0] w_sel_oh;
  logic [N-1:0] w_clr;

  // Scan ptr+1 .. ptr+16 (mod 16); the last slot is ptr itself, so the bit just
  // served only wins again when nothing else is pending.
  always_comb begin : sel_scan
    logic         v_found;
    logic [W-1:0] v_idx;
    w_sel   = '0;
    v_found = 1'b0;
    v_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      v_idx = r_ptr + W'(i);
      if (!v_found && r_pending[v_idx]) begin
        v_found = 1'b1;
        w_sel   = v_idx;
      end
    end
  end

  assign w_any    = |r_pending;
  assign w_load   = ~r_valid | ready;
  assign w_take   = w_load & w_any;
  assign w_sel_oh = {{(N-1){1'b0}}, 1'b1} << w_sel;
  assign w_clr    = w_take ? w_sel_oh : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_y       <= '0;
      r_onehot  <= '0;
      r_ptr     <= {W{1'b1}};
    end else begin
      // New requests are OR'd in after the clear so a same-edge re-request survives.
      r_pending <= req | (r_pending & ~w_clr);
      if (w_load) begin
        if (w_any) begin
          r_valid  <= 1'b1;
          r_y      <= w_sel;
          r_onehot <= w_sel_oh;
          r_ptr    <= w_sel;
        end else begin
          r_valid  <= 1'b0;
          r_onehot <= '0;
        end
      end
    end
  end

  assign valid   = r_valid;
  assign y       = r_y;
  assign onehot  = r_onehot;
  assign pending = r_pending;
  assign busy    = w_any | r_valid;

endmodule

// File: tb/tb_req_rr_encoder16.sv
// Directed bench for req_rr_encoder16: a per-cycle vector table followed by
// hand-written burst and async-reset sequences.
module tb_req_rr_encoder16;

  typedef struct {
    logic [15:0] req;
    logic        ready;
    logic        valid;
    logic [3:0]  y;
    logic [15:0] onehot;
    logic [15:0] pending;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        ready;
  logic        valid;
  logic [3:0]  y;
  logic [15:0] onehot;
  logic [15:0] pending;
  logic        busy;

  int n_cmp;
  int n_err;
  vec_t tbl[24];

  req_rr_encoder16 dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .ready  (ready),
    .valid  (valid),
    .y      (y),
    .onehot (onehot),
    .pending(pending),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [15:0] rq, input logic rd, input logic v,
                              input logic [3:0] yy, input logic [15:0] oh,
                              input logic [15:0] pd);
    vec_t t;
    t.req = rq; t.ready = rd; t.valid = v; t.y = yy; t.onehot = oh; t.pending = pd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [3:0] ey,
                         input logic [15:0] eoh, input logic [15:0] epd);
    chk({tag, " valid"},   {15'd0, valid}, {15'd0, ev});
    chk({tag, " y"},       {12'd0, y},     {12'd0, ey});
    chk({tag, " onehot"},  onehot,         eoh);
    chk({tag, " pending"}, pending,        epd);
    chk({tag, " busy"},    {15'd0, busy},  {15'd0, (epd != 16'h0) | ev});
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic [15:0] rq, input logic rd);
    req   = rq;
    ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    req   = '0;
    ready = 1'b0;

    tbl[0]  = mk(16'h0020, 1, 0, 4'd0, 16'h0000, 16'h0020);
    tbl[1]  = mk(16'h0000, 1, 1, 4'd5, 16'h0020, 16'h0000);
    tbl[2]  = mk(16'h0000, 1, 0, 4'd5, 16'h0000, 16'h0000);
    tbl[3]  = mk(16'h0204, 1, 0, 4'd5, 16'h0000, 16'h0204);
    tbl[4]  = mk(16'h0000, 1, 1, 4'd9, 16'h0200, 16'h0004);
    tbl[5]  = mk(16'h0000, 1, 1, 4'd2, 16'h0004, 16'h0000);
    tbl[6]  = mk(16'h0000, 1, 0, 4'd2, 16'h0000, 16'h0000);
    tbl[7]  = mk(16'h0008, 0, 0, 4'd2, 16'h0000, 16'h0008);
    tbl[8]  = mk(16'h0000, 0, 1, 4'd3, 16'h0008, 16'h0000);
    tbl[9]  = mk(16'h0001, 0, 1, 4'd3, 16'h0008, 16'h0001);
    tbl[10] = mk(16'h0000, 0, 1, 4'd3, 16'h0008, 16'h0001);
    tbl[11] = mk(16'h0000, 0, 1, 4'd3, 16'h0008, 16'h0001);
    tbl[12] = mk(16'h0000, 0, 1, 4'd3, 16'h0008, 16'h0001);
    tbl[13] = mk(16'h0000, 0, 1, 4'd3, 16'h0008, 16'h0001);
    tbl[14] = mk(16'h0000, 1, 1, 4'd0, 16'h0001, 16'h0000);
    tbl[15] = mk(16'h0000, 1, 0, 4'd0, 16'h0000, 16'h0000);
    tbl[16] = mk(16'h0080, 1, 0, 4'd0, 16'h0000, 16'h0080);
    tbl[17] = mk(16'h0080, 1, 1, 4'd7, 16'h0080, 16'h0080);
    tbl[18] = mk(16'h0000, 1, 1, 4'd7, 16'h0080, 16'h0000);
    tbl[19] = mk(16'h0000, 1, 0, 4'd7, 16'h0000, 16'h0000);
    tbl[20] = mk(16'h0002, 0, 0, 4'd7, 16'h0000, 16'h0002);
    tbl[21] = mk(16'h0002, 0, 1, 4'd1, 16'h0002, 16'h0002);
    tbl[22] = mk(16'h0000, 1, 1, 4'd1, 16'h0002, 16'h0000);
    tbl[23] = mk(16'h0000, 1, 0, 4'd1, 16'h0000, 16'h0000);

    #2;
    chk_all("reset", 1'b0, 4'd0, 16'h0000, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].req, tbl[i].ready);
      chk_all($sformatf("vec%0d", i), tbl[i].valid, tbl[i].y, tbl[i].onehot, tbl[i].pending);
      @(negedge clk);
    end

    // Full burst from reset priority: y = 0..15 back to back.
    do_reset();
    step(16'hFFFF, 1'b1);
    chk_all("burst load", 1'b0, 4'd0, 16'h0000, 16'hFFFF);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] exp_pd;
      exp_pd = (32'h0000FFFF << (i + 1)) & 32'h0000FFFF;
      step(16'h0000, 1'b1);
      chk_all($sformatf("burst%0d", i), 1'b1, 4'(i), 16'(32'd1 << i), exp_pd[15:0]);
      @(negedge clk);
    end
    step(16'h0000, 1'b1);
    chk_all("burst end", 1'b0, 4'd15, 16'h0000, 16'h0000);
    @(negedge clk);

    // Async reset between edges during the 4th transfer.
    do_reset();
    step(16'hFFFF, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      step(16'h0000, 1'b1);
      if (i < 3) @(negedge clk);
    end
    chk_all("pre-rst xfer4", 1'b1, 4'd3, 16'h0008, 16'hFFF0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async rst", 1'b0, 4'd0, 16'h0000, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    step(16'h8001, 1'b1);
    chk_all("post-rst load", 1'b0, 4'd0, 16'h0000, 16'h8001);
    @(negedge clk);
    step(16'h0000, 1'b1);
    chk_all("post-rst y0", 1'b1, 4'd0, 16'h0001, 16'h8000);
    @(negedge clk);
    step(16'h0000, 1'b1);
    chk_all("post-rst y15", 1'b1, 4'd15, 16'h8000, 16'h0000);
    @(negedge clk);
    step(16'h0000, 1'b1);
    chk_all("post-rst idle", 1'b0, 4'd15, 16'h0000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
